// File: rtl/rr_online_serial_add_if.sv
// Purpose : handshake/data bundle between a digit-stream producer/consumer and rr_online_serial_add.
// Latency : n/a (wiring only).
// Backpressure: producer offers digit pairs on in_valid, block accepts only while in_ready is high.
// Ports (master = stream source/sink, slave = adder):
//   start, sub, in_valid, x_digit, y_digit        master -> slave
//   in_ready, out_valid, s_digit, out_first,
//   out_last, busy                                slave  -> master
interface rr_online_serial_add_if #(
  parameter int RADIX = 4
);
  localparam int D = $clog2(RADIX) + 1;

  logic                start;
  logic                sub;
  logic                in_valid;
  logic signed [D-1:0] x_digit;
  logic signed [D-1:0] y_digit;
  logic                in_ready;
  logic                out_valid;
  logic signed [D-1:0] s_digit;
  logic                out_first;
  logic                out_last;
  logic                busy;

  modport master (
    output start, sub, in_valid, x_digit, y_digit,
    input  in_ready, out_valid, s_digit, out_first, out_last, busy
  );

  modport slave (
    input  start, sub, in_valid, x_digit, y_digit,
    output in_ready, out_valid, s_digit, out_first, out_last, busy
  );
endinterface

// File: rtl/rr_online_serial_add.sv
// Purpose : MSDF digit-serial online adder/subtractor, radix 2^k >= 4, digit set [-(RADIX-1), RADIX-1].
// Latency : online delay 1; each accepted pair yields s_{j-1} the next cycle, s_WIDTH one cycle after FLUSH.
// Backpressure: in_ready high only in RUN; in_valid low there stalls everything, no output produced.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of rr_online_serial_add_if (start/sub/in_valid/x_digit/y_digit in,
//          in_ready/out_valid/s_digit/out_first/out_last/busy out)
// RADIX must be a power of two >= 4; radix 2 would need an online delay of 2.
module rr_online_serial_add #(
  parameter int RADIX = 4,
  parameter int WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_online_serial_add_if.slave bus
);

  localparam int D  = $clog2(RADIX) + 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic signed [D:0] A_S    = (D+1)'(RADIX - 1);
  localparam logic [D-1:0]      R_D    = D'(RADIX);
  localparam logic [D-1:0]      T_POS  = D'(1);
  localparam logic [D-1:0]      T_NEG  = '1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [D-1:0]    w_prev_q, w_prev_d;
  logic            sub_q, sub_d;
  logic            first_q, first_d;
  logic            out_valid_q, out_valid_d;
  logic [D-1:0]    s_q, s_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;

  logic            accept;
  logic signed [D:0] xe, yv, ye, p;
  logic [D-1:0]    w, t, s_run;

  assign accept = bus.in_valid && (state_q == RUN);

  // Transfer / interim-sum selection. w and s are kept at D bits: both fit in
  // [-(RADIX-1), RADIX-1], and the +/-RADIX correction is exact modulo 2^D.
  always_comb begin
    xe = {bus.x_digit[D-1], bus.x_digit};
    yv = {bus.y_digit[D-1], bus.y_digit};
    ye = sub_q ? -yv : yv;
    p  = xe + ye;
    if (p >= A_S) begin
      t = T_POS;
      w = p[D-1:0] - R_D;
    end else if (p <= -A_S) begin
      t = T_NEG;
      w = p[D-1:0] + R_D;
    end else begin
      t = '0;
      w = p[D-1:0];
    end
    s_run = w_prev_q + t;
  end

  // State register (plus datapath/output registers).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      w_prev_q    <= '0;
      sub_q       <= 1'b0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      w_prev_q    <= w_prev_d;
      sub_q       <= sub_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (accept && (count_q == CNT_LAST)) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    count_d     = count_q;
    w_prev_d    = w_prev_q;
    sub_d       = sub_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    s_d         = '0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sub_d    = bus.sub;
          count_d  = '0;
          w_prev_d = '0;
          first_d  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          count_d     = count_q + CW'(1);
          w_prev_d    = w;
          first_d     = 1'b0;
          out_valid_d = 1'b1;
          s_d         = s_run;
          out_first_d = first_q;
        end
      end
      FLUSH: begin
        // No later transfer can arrive, so the last digit is the bare interim sum.
        out_valid_d = 1'b1;
        s_d         = w_prev_q;
        out_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.s_digit   = s_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rr_online_serial_add.sv
// Purpose : directed check of rr_online_serial_add at RADIX=4, WIDTH=4.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: exercised through in_valid gaps between digit pairs.
module tb_rr_online_serial_add;

  localparam int RADIX = 4;
  localparam int WIDTH = 4;
  localparam int D     = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rr_online_serial_add_if #(.RADIX(RADIX)) bus ();

  rr_online_serial_add #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation. gap = idle in_valid cycles between digit pairs.
  // sub is flipped right after start to show the latched mode is used.
  task automatic run_op(input string tag, input int xs[4], input int ys[4], input logic sb,
                        input int gap, input int es[5]);
    bus.start = 1'b1;
    bus.sub   = sb;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sub   = ~sb;
    chk({tag, " busy_run"}, 32'(bus.busy), 1);
    chk({tag, " rdy_run"}, 32'(bus.in_ready), 1);
    for (int j = 0; j < WIDTH; j++) begin
      if (j > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          chk({tag, " gap_vld"}, 32'(bus.out_valid), 0);
          chk({tag, " gap_rdy"}, 32'(bus.in_ready), 1);
        end
      end
      bus.in_valid = 1'b1;
      bus.x_digit  = D'(xs[j]);
      bus.y_digit  = D'(ys[j]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("%s vld%0d", tag, j), 32'(bus.out_valid), 1);
      chk($sformatf("%s s%0d", tag, j), $signed(bus.s_digit), es[j]);
      chk($sformatf("%s first%0d", tag, j), 32'(bus.out_first), (j == 0) ? 1 : 0);
      chk($sformatf("%s last%0d", tag, j), 32'(bus.out_last), 0);
    end
    chk({tag, " busy_flush"}, 32'(bus.busy), 1);
    chk({tag, " rdy_flush"}, 32'(bus.in_ready), 0);
    @(negedge clk);
    chk({tag, " vld4"}, 32'(bus.out_valid), 1);
    chk({tag, " s4"}, $signed(bus.s_digit), es[4]);
    chk({tag, " last4"}, 32'(bus.out_last), 1);
    chk({tag, " first4"}, 32'(bus.out_first), 0);
    chk({tag, " busy_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_digit  = 3'sd1;
    bus.y_digit  = 3'sd1;
    repeat (2) @(negedge clk);
    chk("rst vld", 32'(bus.out_valid), 0);
    chk("rst s", $signed(bus.s_digit), 0);
    chk("rst first", 32'(bus.out_first), 0);
    chk("rst last", 32'(bus.out_last), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst rdy", 32'(bus.in_ready), 0);
    rst_n = 1'b1;
    // in_valid without start in IDLE must be ignored.
    @(negedge clk);
    chk("idle vld", 32'(bus.out_valid), 0);
    chk("idle busy", 32'(bus.busy), 0);
    bus.in_valid = 1'b0;

    run_op("sat",   '{3, 3, 3, 3},   '{3, 3, 3, 3},   1'b0, 0, '{1, 3, 3, 3, 2});
    run_op("notr",  '{1, 0, -2, 3},  '{1, 0, 2, -3},  1'b0, 0, '{0, 2, 0, 0, 0});
    run_op("neg",   '{0, -3, 0, 0},  '{0, 0, 0, 0},   1'b0, 0, '{0, -1, 1, 0, 0});
    run_op("subme", '{2, 1, -3, 3},  '{2, 1, -3, 3},  1'b1, 0, '{0, 0, 0, 0, 0});
    // Back-to-back: started in the cycle right after the previous out_last.
    run_op("b2b",   '{1, 0, -2, 3},  '{1, 0, 2, -3},  1'b0, 0, '{0, 2, 0, 0, 0});
    run_op("subx",  '{1, 2, 0, -1},  '{-2, 3, 1, 0},  1'b1, 0, '{1, -1, -1, -1, -1});
    run_op("stall", '{3, 3, 3, 3},   '{3, 3, 3, 3},   1'b0, 2, '{1, 3, 3, 3, 2});

    // Reset after the second accept of a saturating add.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_digit  = 3'sd3;
    bus.y_digit  = 3'sd3;
    @(negedge clk);
    chk("mid s0", $signed(bus.s_digit), 1);
    @(negedge clk);
    chk("mid s1", $signed(bus.s_digit), 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst vld", 32'(bus.out_valid), 0);
    chk("mid rst busy", 32'(bus.busy), 0);
    chk("mid rst rdy", 32'(bus.in_ready), 0);
    chk("mid rst s", $signed(bus.s_digit), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post rst vld%0d", k), 32'(bus.out_valid), 0);
      chk($sformatf("post rst busy%0d", k), 32'(bus.busy), 0);
    end
    bus.in_valid = 1'b0;
    run_op("sat2",  '{3, 3, 3, 3},   '{3, 3, 3, 3},   1'b0, 0, '{1, 3, 3, 3, 2});

    repeat (2) @(negedge clk);
    chk("end vld", 32'(bus.out_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
